// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: read sequencer for one Weight_Memory instance.
//   On an accepted start it issues len consecutive reads from base_addr (wrapping
//   at numWeight), soaks up the one-cycle read latency in a 2-entry skid FIFO and
//   streams the weights to the neuron MAC over a valid/ready handshake.
// Optional feature macro: WFC_STALL_CNT_EN adds the stall_cnt output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr,   sequence request; base/len sampled with start in IDLE
//   len
//   busy, done          sequence in progress / one-cycle completion pulse
//   mem_ren, mem_radd   read strobe and address to Weight_Memory
//   mem_rdata           read data, valid the cycle after mem_ren
//   w_data, w_valid,    weight stream to consumer; w_last marks final weight
//   w_ready, w_last
//   stall_cnt           (WFC_STALL_CNT_EN only) cycles stalled by the consumer
module weight_fetch_ctrl #(
  parameter int unsigned numWeight    = 128,
  parameter int unsigned addressWidth = 7,
  parameter int unsigned dataWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addressWidth-1:0] base_addr,
  input  logic [addressWidth:0]   len,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic [dataWidth-1:0]    w_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    w_last
`ifdef WFC_STALL_CNT_EN
  ,output logic [15:0]            stall_cnt
`endif
);

  localparam int unsigned AW    = addressWidth;
  localparam int unsigned LEN_W = addressWidth + 1;
  localparam int unsigned DW    = dataWidth;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_issue_cnt;
  logic             r_inflight;
  logic             r_inflight_last;
  logic [DW-1:0]    r_fifo_data [2];
  logic [1:0]       r_fifo_last;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_fifo_cnt;
`ifdef WFC_STALL_CNT_EN
  logic [15:0]      r_stall_cnt;
`endif

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_issue_last;

  assign w_pop  = w_valid && w_ready;
  assign w_push = r_inflight;
  // Slots already claimed: stored entries plus the read whose data lands this cycle.
  assign w_occ  = 3'(r_fifo_cnt) + 3'(r_inflight);
  // Issue only if the returning data is guaranteed a FIFO slot, counting this cycle's pop.
  assign w_issue = (r_state == S_RUN) && (r_issue_cnt != '0) &&
                   (w_occ < (3'd2 + 3'(w_pop)));
  assign w_issue_last = w_issue && (r_issue_cnt == LEN_W'(1));

  assign mem_ren  = w_issue;
  assign mem_radd = r_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_valid  = (r_fifo_cnt != 2'd0);
  assign w_data   = r_fifo_data[r_rd_ptr];
  assign w_last   = w_valid && r_fifo_last[r_rd_ptr];
`ifdef WFC_STALL_CNT_EN
  assign stall_cnt = r_stall_cnt;
`endif

  // Sequencer FSM, address/issue counters, skid FIFO and optional stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_issue_cnt     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= '0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_fifo_cnt      <= 2'd0;
`ifdef WFC_STALL_CNT_EN
      r_stall_cnt     <= '0;
`endif
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_rdata;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);

      if (w_issue) begin
        r_addr      <= (r_addr == AW'(numWeight - 1)) ? '0 : r_addr + AW'(1);
        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
      end

`ifdef WFC_STALL_CNT_EN
      if (busy && w_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_issue_cnt <= len;
            r_state     <= S_RUN;
`ifdef WFC_STALL_CNT_EN
            r_stall_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          // An empty sequence spends one busy cycle here before reporting done.
          if (r_issue_cnt == '0) begin
            r_state <= S_DONE;
          end else if (w_issue_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
